// File: rtl/pkg_tpu.sv
// Shared TPU types: address/data widths and the DMem lane-port FSM encoding.
package pkg_tpu;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  typedef logic [ADDR_W-1:0] address_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RDY,
    XFER,
    DRAIN,
    DONE
  } dport_fsm_t;

endpackage

// File: rtl/DPort_LdFIFO.sv
// Load-return buffer: power-of-two circular FIFO exposing its occupancy.
module DPort_LdFIFO
  import pkg_tpu::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  data_t                    i_data,
  input  logic                     i_pop,
  output data_t                    o_head,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  data_t         r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  // A pop in the same cycle frees the slot, so a push at full is still legal.
  assign w_push = i_push && ((r_count != FULL) || w_pop);

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/dmem_lane_port.sv
// Lane-side DMem port: runs one strided store or load command per request/grant handshake,
// with credit-limited load issue into a local return FIFO.
module dmem_lane_port
  import pkg_tpu::*;
#(
  parameter int unsigned LD_FIFO_DEPTH = 4
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     I_Cmd_Valid,
  input  logic     I_Cmd_Store,
  input  address_t I_Length,
  input  address_t I_Stride,
  input  address_t I_Base_Addr,
  output logic     O_Cmd_Ready,
  input  logic     I_Src_Valid,
  input  data_t    I_Src_Data,
  output logic     O_Src_Ready,
  output logic     O_Dst_Valid,
  output data_t    O_Dst_Data,
  input  logic     I_Dst_Ready,
  output logic     O_St_Req,
  output address_t O_St_Length,
  output address_t O_St_Stride,
  output address_t O_St_Base_Addr,
  input  logic     I_St_Grant,
  input  logic     I_St_Ready,
  output logic     O_St_Valid,
  output data_t    O_St_Data,
  output logic     O_Ld_Req,
  output address_t O_Ld_Length,
  output address_t O_Ld_Stride,
  output address_t O_Ld_Base_Addr,
  input  logic     I_Ld_Grant,
  input  logic     I_Ld_Ready,
  output logic     O_Ld_Valid,
  input  data_t    I_Ld_Data,
  output logic     O_Busy,
  output logic     O_Done
);

  localparam int unsigned CW = $clog2(LD_FIFO_DEPTH) + 1;

  dport_fsm_t r_state;
  dport_fsm_t w_state_nxt;
  logic       r_store;
  address_t   r_len;
  address_t   r_stride;
  address_t   r_base;
  address_t   r_beats;
  logic       r_inflight;

  logic [CW-1:0] w_fifo_count;
  logic          w_fifo_empty;
  data_t         w_fifo_head;
  logic          w_grant;
  logic          w_ready;
  logic          w_credit;
  logic          w_beat;
  logic          w_last;
  logic          w_accept;

  assign w_grant  = r_store ? I_St_Grant : I_Ld_Grant;
  assign w_ready  = r_store ? I_St_Ready : I_Ld_Ready;
  // Room for one more return word once buffered and in-flight data are counted.
  assign w_credit = ({1'b0, w_fifo_count} + (CW + 1)'(r_inflight)) < (CW + 1)'(LD_FIFO_DEPTH);
  assign w_beat   = (r_state == XFER) && w_grant && w_ready &&
                    (r_store ? I_Src_Valid : w_credit);
  assign w_last   = (r_beats + 1'b1) == r_len;

  assign O_Cmd_Ready = (r_state == IDLE) && !reset;
  assign w_accept    = I_Cmd_Valid && O_Cmd_Ready;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:     if (w_accept) w_state_nxt = (I_Length == '0) ? DONE : REQ;
      REQ:      if (w_grant) w_state_nxt = w_ready ? XFER : WAIT_RDY;
      WAIT_RDY: if (w_grant && w_ready) w_state_nxt = XFER;
      XFER:     if (w_beat && w_last) w_state_nxt = r_store ? DONE : DRAIN;
      DRAIN:    if (!r_inflight && w_fifo_empty) w_state_nxt = DONE;
      DONE:     w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_store    <= 1'b0;
      r_len      <= '0;
      r_stride   <= '0;
      r_base     <= '0;
      r_beats    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_beat && !r_store;
      if (w_accept) begin
        r_store  <= I_Cmd_Store;
        r_len    <= I_Length;
        r_stride <= I_Stride;
        r_base   <= I_Base_Addr;
        r_beats  <= '0;
      end else if (w_beat) begin
        r_beats  <= r_beats + 1'b1;
      end
    end
  end

  DPort_LdFIFO #(
    .DEPTH (LD_FIFO_DEPTH)
  ) u_ld_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_data  (I_Ld_Data),
    .i_pop   (O_Dst_Valid && I_Dst_Ready),
    .o_head  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign O_St_Req       = (r_state == REQ) && r_store;
  assign O_Ld_Req       = (r_state == REQ) && !r_store;
  assign O_St_Length    = r_len;
  assign O_St_Stride    = r_stride;
  assign O_St_Base_Addr = r_base;
  assign O_Ld_Length    = r_len;
  assign O_Ld_Stride    = r_stride;
  assign O_Ld_Base_Addr = r_base;

  assign O_St_Valid  = w_beat && r_store;
  assign O_Src_Ready = w_beat && r_store;
  assign O_St_Data   = O_St_Valid ? I_Src_Data : '0;
  assign O_Ld_Valid  = w_beat && !r_store;

  assign O_Dst_Valid = !w_fifo_empty;
  assign O_Dst_Data  = w_fifo_empty ? '0 : w_fifo_head;

  assign O_Busy = (r_state != IDLE);
  assign O_Done = (r_state == DONE);

endmodule

// File: tb/tb_dmem_lane_port.sv
// Randomized bench for dmem_lane_port with a queue-based DMem/source/sink model.
module tb_dmem_lane_port;
  import pkg_tpu::*;

  localparam int unsigned DEPTH = 4;

  logic     clock = 1'b0;
  logic     reset;
  logic     I_Cmd_Valid, I_Cmd_Store;
  address_t I_Length, I_Stride, I_Base_Addr;
  logic     O_Cmd_Ready;
  logic     I_Src_Valid;
  data_t    I_Src_Data;
  logic     O_Src_Ready;
  logic     O_Dst_Valid;
  data_t    O_Dst_Data;
  logic     I_Dst_Ready;
  logic     O_St_Req;
  address_t O_St_Length, O_St_Stride, O_St_Base_Addr;
  logic     I_St_Grant, I_St_Ready, O_St_Valid;
  data_t    O_St_Data;
  logic     O_Ld_Req;
  address_t O_Ld_Length, O_Ld_Stride, O_Ld_Base_Addr;
  logic     I_Ld_Grant, I_Ld_Ready, O_Ld_Valid;
  data_t    I_Ld_Data;
  logic     O_Busy, O_Done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  dmem_lane_port #(
    .LD_FIFO_DEPTH (DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .I_Cmd_Valid    (I_Cmd_Valid),
    .I_Cmd_Store    (I_Cmd_Store),
    .I_Length       (I_Length),
    .I_Stride       (I_Stride),
    .I_Base_Addr    (I_Base_Addr),
    .O_Cmd_Ready    (O_Cmd_Ready),
    .I_Src_Valid    (I_Src_Valid),
    .I_Src_Data     (I_Src_Data),
    .O_Src_Ready    (O_Src_Ready),
    .O_Dst_Valid    (O_Dst_Valid),
    .O_Dst_Data     (O_Dst_Data),
    .I_Dst_Ready    (I_Dst_Ready),
    .O_St_Req       (O_St_Req),
    .O_St_Length    (O_St_Length),
    .O_St_Stride    (O_St_Stride),
    .O_St_Base_Addr (O_St_Base_Addr),
    .I_St_Grant     (I_St_Grant),
    .I_St_Ready     (I_St_Ready),
    .O_St_Valid     (O_St_Valid),
    .O_St_Data      (O_St_Data),
    .O_Ld_Req       (O_Ld_Req),
    .O_Ld_Length    (O_Ld_Length),
    .O_Ld_Stride    (O_Ld_Stride),
    .O_Ld_Base_Addr (O_Ld_Base_Addr),
    .I_Ld_Grant     (I_Ld_Grant),
    .I_Ld_Ready     (I_Ld_Ready),
    .O_Ld_Valid     (O_Ld_Valid),
    .I_Ld_Data      (I_Ld_Data),
    .O_Busy         (O_Busy),
    .O_Done         (O_Done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory contents seen by the DMem model.
  function automatic data_t ld_mem(input address_t a);
    return {a ^ 16'hA5C3, ~a};
  endfunction

  function automatic address_t beat_addr(input address_t base, input address_t stride, input int k);
    return base + stride * address_t'(k);
  endfunction

  task automatic idle_inputs();
    I_Cmd_Valid = 1'b0; I_Cmd_Store = 1'b0;
    I_Length = '0; I_Stride = '0; I_Base_Addr = '0;
    I_Src_Valid = 1'b0; I_Src_Data = '0; I_Dst_Ready = 1'b0;
    I_St_Grant = 1'b0; I_St_Ready = 1'b0;
    I_Ld_Grant = 1'b0; I_Ld_Ready = 1'b0; I_Ld_Data = '0;
  endtask

  // One command end to end. Cycle 1 is the cycle right after the accepting edge.
  task automatic run_txn(input bit store, input int len, input address_t stride,
                         input address_t base, input int g_dly, input int r_dly, input bit rnd,
                         input int dst_hold, input int drop_at);
    data_t exp_q[$];
    data_t got_q[$];
    int src_idx = 0, issued = 0, popped = 0, dones = 0, done_cyc = 0, last_beat = 0;
    int drop_cnt = 0, max_out = 0, ld_idx = 0;
    bit ld_due = 0, req_seen = 0, fin = 0, g, r;

    for (int i = 0; i < len; i++)
      exp_q.push_back(store ? data_t'($urandom) : ld_mem(beat_addr(base, stride, i)));

    @(negedge clock);
    I_Cmd_Valid = 1'b1; I_Cmd_Store = store;
    I_Length = address_t'(len); I_Stride = stride; I_Base_Addr = base;
    #1;
    check("cmd_ready", O_Cmd_Ready, 1'b1);

    for (int cyc = 1; cyc < 3000 && !fin; cyc++) begin
      @(negedge clock);
      I_Cmd_Valid = 1'b0;
      I_Ld_Data = ld_due ? ld_mem(beat_addr(base, stride, ld_idx)) : data_t'($urandom);
      ld_due = 0;
      g = (cyc >= g_dly) && (!rnd || $urandom_range(7) != 0);
      r = (cyc >= r_dly) && (!rnd || $urandom_range(3) != 0);
      if (drop_at != 0 && issued == drop_at && drop_cnt < 3) begin
        r = 1'b0;
        drop_cnt++;
      end
      I_St_Grant = store & g;  I_St_Ready = store & r;
      I_Ld_Grant = !store & g; I_Ld_Ready = !store & r;
      I_Src_Valid = store && (!rnd || $urandom_range(3) != 0);
      I_Src_Data  = (store && src_idx < len) ? exp_q[src_idx] : data_t'($urandom);
      I_Dst_Ready = (cyc > dst_hold) && (!rnd || $urandom_range(1) != 0);
      #1;
      if (dst_hold > 0 && cyc == dst_hold) check("ld_credit_stall", issued, DEPTH);
      if ((O_St_Req || O_Ld_Req) && !req_seen) begin
        req_seen = 1;
        check("req_side", {O_St_Req, O_Ld_Req}, store ? 2'b10 : 2'b01);
        check("req_len", store ? O_St_Length : O_Ld_Length, len);
        check("req_stride", store ? O_St_Stride : O_Ld_Stride, stride);
        check("req_base", store ? O_St_Base_Addr : O_Ld_Base_Addr, base);
      end
      if (O_St_Valid || O_Src_Ready) begin
        check("st_handshake", {I_St_Grant, I_St_Ready, I_Src_Valid, O_St_Valid, O_Src_Ready},
              5'h1F);
        got_q.push_back(O_St_Data);
        src_idx++;
        issued++;
        last_beat = cyc;
      end
      if (O_Ld_Valid) begin
        check("ld_handshake", {I_Ld_Grant, I_Ld_Ready}, 2'b11);
        ld_due = 1;
        ld_idx = issued;
        issued++;
      end
      if (O_Dst_Valid && I_Dst_Ready) begin
        got_q.push_back(O_Dst_Data);
        popped++;
      end
      if (!store && issued - popped > max_out) max_out = issued - popped;
      if (O_Done) begin
        dones++;
        done_cyc = cyc;
        fin = 1;
      end
    end

    check("done_seen", fin, 1'b1);
    check("beats_issued", issued, len);
    check("data_count", got_q.size(), len);
    for (int i = 0; i < len && i < got_q.size(); i++)
      check(store ? "st_data" : "ld_data", got_q[i], exp_q[i]);
    if (len == 0) begin
      check("len0_no_req", req_seen, 1'b0);
      check("len0_done_cyc", done_cyc, 1);
    end else if (store) begin
      check("st_done_latency", done_cyc, last_beat + 1);
    end else begin
      check("ld_outstanding", max_out <= DEPTH, 1'b1);
    end

    @(negedge clock);
    idle_inputs();
    #1;
    check("back_idle", {O_Busy, O_Done, O_Cmd_Ready}, 3'b001);
  endtask

  // Reset while a load has three words parked in the return buffer.
  task automatic reset_mid_load();
    int issued = 0, ld_idx = 0;
    bit ld_due = 0;
    @(negedge clock);
    I_Cmd_Valid = 1'b1; I_Cmd_Store = 1'b0;
    I_Length = 16'd8; I_Stride = 16'd1; I_Base_Addr = 16'h0200;
    for (int cyc = 1; cyc < 40; cyc++) begin
      @(negedge clock);
      I_Cmd_Valid = 1'b0;
      I_Ld_Data = ld_due ? ld_mem(beat_addr(16'h0200, 16'd1, ld_idx)) : '0;
      ld_due = 0;
      I_Ld_Grant = (issued < 3); I_Ld_Ready = 1'b1; I_Dst_Ready = 1'b0;
      #1;
      if (O_Ld_Valid) begin
        ld_due = 1;
        ld_idx = issued;
        issued++;
      end
      if (issued == 3 && !ld_due && cyc > 8) break;
    end
    check("pre_reset_dst_valid", O_Dst_Valid, 1'b1);
    check("pre_reset_busy", O_Busy, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("mid_reset_ctrl", {O_Cmd_Ready, O_Busy, O_Done, O_Dst_Valid, O_Ld_Req, O_Ld_Valid,
                             O_St_Req, O_St_Valid, O_Src_Ready}, 9'h0);
    check("mid_reset_data", {O_Dst_Data, O_St_Data}, 64'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    idle_inputs();
    #1;
    check("post_reset_cmd_ready", O_Cmd_Ready, 1'b1);
    check("post_reset_no_dst", {O_Dst_Valid, O_Busy}, 2'b00);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #2;
    check("reset_outputs", {O_Cmd_Ready, O_Busy, O_Done, O_Dst_Valid, O_Ld_Req, O_Ld_Valid,
                            O_St_Req, O_St_Valid, O_Src_Ready}, 9'h0);
    check("reset_lengths", {O_St_Length, O_Ld_Length, O_St_Base_Addr, O_Ld_Base_Addr}, 64'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("release_cmd_ready", O_Cmd_Ready, 1'b1);

    run_txn(1'b1, 4, 16'd1, 16'h0010, 3, 5, 1'b0, 0, 0);   // store, grant @3 ready @5
    run_txn(1'b0, 8, 16'd2, 16'h0100, 1, 1, 1'b0, 20, 0);  // load with sink held off
    run_txn(1'b0, 0, 16'd1, 16'h0040, 1, 1, 1'b0, 0, 0);   // zero-length load
    run_txn(1'b1, 6, 16'd1, 16'h0080, 1, 1, 1'b0, 0, 2);   // ready dropped after beat 2
    run_txn(1'b0, 5, 16'd3, 16'h0300, 2, 4, 1'b0, 0, 0);   // ready after grant

    for (int t = 0; t < 14; t++)
      run_txn(1'($urandom_range(1)), $urandom_range(10), address_t'($urandom_range(1, 8)),
              address_t'($urandom), $urandom_range(1, 4), $urandom_range(1, 6), 1'b1, 0, 0);

    reset_mid_load();
    run_txn(1'b0, 6, 16'd1, 16'h0400, 1, 1, 1'b1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
